smpl_cpu3: RTL and testbench
============================

Name: smpl_cpu3

Overview:
- Parametrised multi-cycle successor to the accumulator CPU: the same single-accumulator ISA model, generalised in data and address width.
- Adds a ready/handshake data-memory interface with wait states, an explicit IDLE/HALT lifecycle and status outputs.
- Sits between a single-cycle instruction ROM and a data memory that may stall.

Parameters:
- DW, 16: data/instruction width.
- AW, 13: instruction- and data-address width. Must satisfy DW >= AW+3; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  launch program from PC=0 when in IDLE or HALT
- im_abus  out  AW  instruction address (= PC)
- im_dbus  in  DW  instruction word, valid combinationally in the same cycle
- rd_mem  out  1  data-memory read request
- wr_mem  out  1  data-memory write request
- dm_abus  out  AW  data address (= IR[AW-1:0])
- dm_in_dbus  out  DW  write data to memory (= AC)
- dm_out_dbus  in  DW  read data from memory
- dm_ready  in  1  memory completes current request this cycle
- zero_ac  out  1  AC == 0
- halted  out  1  state == HALT
- busy  out  1  state not IDLE and not HALT

Behaviour:
- Instruction format: opcode = IR[DW-1:DW-3]; address field = IR[AW-1:0]; remaining bits ignored.
- Opcodes:
  - 000 LDA: AC<=M[a]
  - 001 STA: M[a]<=AC
  - 010 ADD: AC<=AC+M[a], mod 2^DW, carry dropped
  - 011 AND: AC<=AC&M[a]
  - 100 JMP: PC<=a
  - 101 JZ: if AC==0 then PC<=a
  - 110 NOT: AC<=~AC
  - 111 HLT
- Reset (reset=0, asynchronous): state=IDLE, PC=0, AC=0, IR=0. rd_mem=wr_mem=0, im_abus=0, dm_abus=0, dm_in_dbus=0, zero_ac=1, halted=0, busy=0.
- States: IDLE, FETCH, EXEC, WAIT, HALT.
- IDLE: start=1 -> PC<=0, go FETCH. Otherwise hold.
- FETCH: IR<=im_dbus; PC<=PC+1, wrapping from 2^AW-1 to 0; go EXEC.
- EXEC:
  - JMP/JZ/NOT: complete in this cycle; go FETCH. JZ samples the AC value held in EXEC.
  - HLT: go HALT; PC holds the address after the HLT.
  - LDA/ADD/AND: assert rd_mem. STA: assert wr_mem.
    - dm_ready=1 this cycle: complete (AC updated at the clock edge for reads); go FETCH.
    - dm_ready=0: go WAIT.
- WAIT: hold rd_mem/wr_mem, dm_abus and dm_in_dbus stable. First cycle with dm_ready=1 completes the op; go FETCH.
- rd_mem/wr_mem are decoded from state and IR. They are never both high and are 0 outside EXEC/WAIT.
- Latency: 2 cycles per instruction with zero wait states; memory ops take 2+N cycles for N wait cycles.
- HALT: hold all registers. start=1 -> PC<=0, go FETCH; AC is not cleared.
- start is ignored in FETCH/EXEC/WAIT. dm_ready is ignored when no request is active.
- Reset during WAIT aborts the access; rd_mem/wr_mem fall immediately and asynchronously.
- zero_ac is combinational from AC.

Test Plan:
- Reset, then start pulse with program {LDA 5, ADD 6, STA 7, HLT}, M[5]=3, M[6]=4, dm_ready tied 1 -> M[7]=7, halted=1 after exactly 8 cycles from the first FETCH, AC=7.
- Same program with dm_ready low for 3 cycles on each access -> 17 cycles; rd_mem/dm_abus stable through WAIT; M[7]=7.
- AC=0xFFFF, ADD with M=2 -> AC=0x0001, zero_ac=0; AC=0x1234 then NOT -> 0xEDCB.
- JZ with AC=0 -> PC=target; JZ with AC=1 -> PC=next; JMP to 2^AW-1 -> next fetch wraps to address 0.
- Reset asserted mid-WAIT of STA -> rd_mem=wr_mem=0 immediately, no write completes, IDLE after release. start while busy -> no effect.
- Parameter run DW=12, AW=9: LDA/STA/JMP over the full 512-word range behave correctly.

Source files
------------

// File: rtl/smpl_cpu3.sv
// smpl_cpu3: parametrised multi-cycle accumulator CPU
// with a stallable ready/handshake data-memory port.
module smpl_cpu3 #(
  parameter int DW = 16,
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] im_abus,
  input  logic [DW-1:0] im_dbus,
  output logic          rd_mem,
  output logic          wr_mem,
  output logic [AW-1:0] dm_abus,
  output logic [DW-1:0] dm_in_dbus,
  input  logic [DW-1:0] dm_out_dbus,
  input  logic          dm_ready,
  output logic          zero_ac,
  output logic          halted,
  output logic          busy
);

  // The opcode must sit above the address field.
  generate
    if (DW < AW + 3) begin : g_bad_param
      $error("smpl_cpu3: DW must be >= AW+3");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [DW-1:0] r_ac;
  logic [DW-1:0] w_ac_nxt;
  logic [DW-1:0] r_ir;
  logic [DW-1:0] w_ir_nxt;

  logic [2:0]    w_op;
  logic [AW-1:0] w_addr;
  logic          w_lda;
  logic          w_sta;
  logic          w_add;
  logic          w_and;
  logic          w_jmp;
  logic          w_jz;
  logic          w_not;
  logic          w_hlt;
  logic          w_mem;
  logic          w_act;
  logic          w_zero;
  logic          w_unused_ir;

  assign w_op   = r_ir[DW-1:DW-3];
  assign w_addr = r_ir[AW-1:0];
  assign w_unused_ir = ^r_ir;

  assign w_lda = (w_op == 3'b000);
  assign w_sta = (w_op == 3'b001);
  assign w_add = (w_op == 3'b010);
  assign w_and = (w_op == 3'b011);
  assign w_jmp = (w_op == 3'b100);
  assign w_jz  = (w_op == 3'b101);
  assign w_not = (w_op == 3'b110);
  assign w_hlt = (w_op == 3'b111);
  assign w_mem = w_lda | w_sta | w_add | w_and;

  assign w_act  = (r_state == S_EXEC) || (r_state == S_WAIT);
  assign w_zero = (r_ac == '0);

  assign im_abus    = r_pc;
  assign dm_abus    = w_addr;
  assign dm_in_dbus = r_ac;
  assign rd_mem     = w_act & (w_lda | w_add | w_and);
  assign wr_mem     = w_act & w_sta;
  assign zero_ac    = w_zero;
  assign halted     = (r_state == S_HALT);
  assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);

  // Next-state and datapath update decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ac_nxt    = r_ac;
    w_ir_nxt    = r_ir;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_ir_nxt    = im_dbus;
        w_pc_nxt    = r_pc + AW'(1);
        w_state_nxt = S_EXEC;
      end
      S_EXEC, S_WAIT: begin
        w_state_nxt = S_FETCH;
        unique case (1'b1)
          w_jmp: w_pc_nxt = w_addr;
          w_jz: begin
            if (w_zero) w_pc_nxt = w_addr;
          end
          w_not: w_ac_nxt = ~r_ac;
          w_hlt: w_state_nxt = S_HALT;
          w_mem: begin
            if (dm_ready) begin
              if (w_lda)
                w_ac_nxt = dm_out_dbus;
              else if (w_add)
                w_ac_nxt = r_ac + dm_out_dbus;
              else if (w_and)
                w_ac_nxt = r_ac & dm_out_dbus;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
          default: ;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ac    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ac    <= w_ac_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

endmodule

// File: tb/tb_smpl_cpu3.sv
// tb_smpl_cpu3: directed tests for smpl_cpu3
// at 16/13 and 12/9 widths.
module tb_smpl_cpu3;

  localparam logic [2:0] LDA = 3'b000;
  localparam logic [2:0] STA = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] JMP = 3'b100;
  localparam logic [2:0] JZ  = 3'b101;
  localparam logic [2:0] NOT = 3'b110;
  localparam logic [2:0] HLT = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [12:0] im_abus;
  logic [15:0] im_dbus;
  logic        rd_mem;
  logic        wr_mem;
  logic [12:0] dm_abus;
  logic [15:0] dm_in_dbus;
  logic [15:0] dm_out_dbus;
  logic        dm_ready;
  logic        zero_ac;
  logic        halted;
  logic        busy;

  logic        start2;
  logic [8:0]  im_abus2;
  logic [11:0] im_dbus2;
  logic        rd2;
  logic        wr2;
  logic [8:0]  dm_abus2;
  logic [11:0] dm_in2;
  logic [11:0] dm_out2;
  logic        dm_ready2;
  logic        zero2;
  logic        halted2;
  logic        busy2;

  logic [15:0] rom   [0:8191];
  logic [15:0] dmem  [0:8191];
  logic [11:0] rom2  [0:511];
  logic [11:0] dmem2 [0:511];

  int nwait;
  int ws_cnt;
  int total;
  int bad;
  int trace[$];

  assign im_dbus     = rom[im_abus];
  assign dm_out_dbus = dmem[dm_abus];
  assign dm_ready    = (ws_cnt == nwait);
  assign im_dbus2    = rom2[im_abus2];
  assign dm_out2     = dmem2[dm_abus2];
  assign dm_ready2   = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if ((rd_mem || wr_mem) && !dm_ready)
      ws_cnt <= ws_cnt + 1;
    else
      ws_cnt <= 0;
  end

  smpl_cpu3 #(.DW(16), .AW(13)) u_dut (
    .clk(clk), .reset(rst_n), .start(start),
    .im_abus(im_abus), .im_dbus(im_dbus),
    .rd_mem(rd_mem), .wr_mem(wr_mem),
    .dm_abus(dm_abus), .dm_in_dbus(dm_in_dbus),
    .dm_out_dbus(dm_out_dbus), .dm_ready(dm_ready),
    .zero_ac(zero_ac), .halted(halted), .busy(busy)
  );

  smpl_cpu3 #(.DW(12), .AW(9)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start2),
    .im_abus(im_abus2), .im_dbus(im_dbus2),
    .rd_mem(rd2), .wr_mem(wr2),
    .dm_abus(dm_abus2), .dm_in_dbus(dm_in2),
    .dm_out_dbus(dm_out2), .dm_ready(dm_ready2),
    .zero_ac(zero2), .halted(halted2), .busy(busy2)
  );

  function automatic logic [15:0] i16(
    input logic [2:0] op, input int a);
    return {op, 13'(a)};
  endfunction

  function automatic logic [11:0] i12(
    input logic [2:0] op, input int a);
    return {op, 9'(a)};
  endfunction

  task automatic tick();
    logic        w1;
    logic        w2;
    logic [12:0] a1;
    logic [15:0] d1;
    logic [8:0]  a2;
    logic [11:0] d2;
    w1 = wr_mem && dm_ready;
    a1 = dm_abus;
    d1 = dm_in_dbus;
    w2 = wr2 && dm_ready2;
    a2 = dm_abus2;
    d2 = dm_in2;
    @(posedge clk);
    if (w1) dmem[a1] = d1;
    if (w2) dmem2[a2] = d2;
    #1;
  endtask

  task automatic run1(input logic hold,
    output int cyc, output int waits,
    output int stab);
    logic        p_req, p_rdy, p_rd, p_wr;
    logic [12:0] p_a;
    logic [15:0] p_d;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    waits = 0;
    stab = 0;
    trace.delete();
    while (!halted && cyc < 400) begin
      start = hold;
      p_req = rd_mem | wr_mem;
      p_rdy = dm_ready;
      p_rd  = rd_mem;
      p_wr  = wr_mem;
      p_a   = dm_abus;
      p_d   = dm_in_dbus;
      tick();
      cyc++;
      trace.push_back(int'(im_abus));
      if (p_req && !p_rdy) begin
        waits++;
        if (rd_mem !== p_rd || wr_mem !== p_wr ||
            dm_abus !== p_a || dm_in_dbus !== p_d)
          stab++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    nwait = 0;
    tick();
    tick();
    total++;
    if (rd_mem !== 1'b0 || wr_mem !== 1'b0) begin
      bad++;
      $display("FAIL rst_rdwr: got %b%b want 00",
        rd_mem, wr_mem);
    end
    total++;
    if (im_abus !== 13'd0) begin
      bad++;
      $display("FAIL rst_pc: got %0h want 0", im_abus);
    end
    total++;
    if (dm_abus !== 13'd0 || dm_in_dbus !== 16'd0) begin
      bad++;
      $display("FAIL rst_dm: got %0h/%0h want 0/0",
        dm_abus, dm_in_dbus);
    end
    total++;
    if (zero_ac !== 1'b1) begin
      bad++;
      $display("FAIL rst_zero: got %b want 1", zero_ac);
    end
    total++;
    if (halted !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_status: got h%b b%b want 0 0",
        halted, busy);
    end
    total++;
    if (halted2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL rst_status2: got h%b b%b want 0 0",
        halted2, busy2);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_basic();
    rom[0] = i16(LDA, 5);
    rom[1] = i16(ADD, 6);
    rom[2] = i16(STA, 7);
    rom[3] = i16(HLT, 0);
    dmem[5] = 16'd3;
    dmem[6] = 16'd4;
    dmem[7] = 16'd0;
  endtask

  task automatic test_basic();
    int cyc, waits, stab;
    load_basic();
    nwait = 0;
    run1(1'b0, cyc, waits, stab);
    total++;
    if (cyc !== 8) begin
      bad++;
      $display("FAIL basic_cyc: got %0d want 8", cyc);
    end
    total++;
    if (dmem[7] !== 16'd7) begin
      bad++;
      $display("FAIL basic_m7: got %0h want 7", dmem[7]);
    end
    total++;
    if (dm_in_dbus !== 16'd7) begin
      bad++;
      $display("FAIL basic_ac: got %0h want 7", dm_in_dbus);
    end
    total++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_stat: got h%b b%b want 1 0",
        halted, busy);
    end
    total++;
    if (im_abus !== 13'd4) begin
      bad++;
      $display("FAIL basic_pc: got %0h want 4", im_abus);
    end
    total++;
    if (waits !== 0) begin
      bad++;
      $display("FAIL basic_waits: got %0d want 0", waits);
    end
  endtask

  task automatic test_wait_states();
    int cyc, waits, stab;
    load_basic();
    nwait = 3;
    run1(1'b0, cyc, waits, stab);
    nwait = 0;
    total++;
    if (cyc !== 17) begin
      bad++;
      $display("FAIL wait_cyc: got %0d want 17", cyc);
    end
    total++;
    if (waits !== 9) begin
      bad++;
      $display("FAIL wait_count: got %0d want 9", waits);
    end
    total++;
    if (stab !== 0) begin
      bad++;
      $display("FAIL wait_stable: got %0d want 0", stab);
    end
    total++;
    if (dmem[7] !== 16'd7 || dm_in_dbus !== 16'd7) begin
      bad++;
      $display("FAIL wait_m7: got %0h/%0h want 7/7",
        dmem[7], dm_in_dbus);
    end
  endtask

  task automatic test_arith();
    int cyc, waits, stab;
    dmem[10] = 16'hFFFF;
    dmem[11] = 16'h0002;
    dmem[12] = 16'h1234;
    dmem[13] = 16'h0FF0;
    dmem[15] = 16'h0001;
    rom[0] = i16(LDA, 10);
    rom[1] = i16(ADD, 11);
    rom[2] = i16(HLT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (dm_in_dbus !== 16'h0001 || zero_ac !== 1'b0) begin
      bad++;
      $display("FAIL add_wrap: got %0h z%b want 1 z0",
        dm_in_dbus, zero_ac);
    end
    total++;
    if (cyc !== 6) begin
      bad++;
      $display("FAIL add_cyc: got %0d want 6", cyc);
    end
    rom[1] = i16(ADD, 15);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (dm_in_dbus !== 16'h0000 || zero_ac !== 1'b1) begin
      bad++;
      $display("FAIL add_zero: got %0h z%b want 0 z1",
        dm_in_dbus, zero_ac);
    end
    rom[0] = i16(LDA, 12);
    rom[1] = i16(NOT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (dm_in_dbus !== 16'hEDCB) begin
      bad++;
      $display("FAIL not: got %0h want EDCB", dm_in_dbus);
    end
    rom[0] = i16(NOT, 0);
    rom[1] = i16(HLT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (dm_in_dbus !== 16'h1234) begin
      bad++;
      $display("FAIL ac_kept: got %0h want 1234", dm_in_dbus);
    end
    rom[0] = i16(LDA, 12);
    rom[1] = i16(AND, 13);
    rom[2] = i16(HLT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (dm_in_dbus !== 16'h0230) begin
      bad++;
      $display("FAIL and: got %0h want 0230", dm_in_dbus);
    end
  endtask

  task automatic test_jumps();
    int cyc, waits, stab;
    dmem[20] = 16'h0000;
    dmem[21] = 16'h0001;
    rom[0] = i16(LDA, 20);
    rom[1] = i16(JZ, 5);
    rom[2] = i16(HLT, 0);
    rom[5] = i16(HLT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (im_abus !== 13'd6 || cyc !== 6) begin
      bad++;
      $display("FAIL jz_taken: got pc %0h c%0d want 6 c6",
        im_abus, cyc);
    end
    rom[0] = i16(LDA, 21);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (im_abus !== 13'd3 || cyc !== 6) begin
      bad++;
      $display("FAIL jz_not: got pc %0h c%0d want 3 c6",
        im_abus, cyc);
    end
    rom[0] = i16(JMP, 8191);
    rom[8191] = i16(HLT, 0);
    run1(1'b0, cyc, waits, stab);
    total++;
    if (trace.size() < 2 || trace[1] !== 8191) begin
      bad++;
      $display("FAIL jmp_top: got %0d want 8191",
        (trace.size() < 2) ? -1 : trace[1]);
    end
    total++;
    if (im_abus !== 13'd0 || cyc !== 4 || halted !== 1'b1) begin
      bad++;
      $display("FAIL pc_wrap: got pc %0h c%0d want 0 c4",
        im_abus, cyc);
    end
  endtask

  task automatic test_reset_in_wait();
    dmem[30] = 16'hAAAA;
    rom[0] = i16(STA, 30);
    rom[1] = i16(HLT, 0);
    nwait = 100;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (wr_mem !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL sta_wait: got w%b b%b want 1 1",
        wr_mem, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_mem !== 1'b0 || rd_mem !== 1'b0) begin
      bad++;
      $display("FAIL async_abort: got %b%b want 00",
        rd_mem, wr_mem);
    end
    tick();
    tick();
    rst_n = 1'b1;
    nwait = 0;
    tick();
    tick();
    total++;
    if (dmem[30] !== 16'hAAAA) begin
      bad++;
      $display("FAIL no_write: got %0h want AAAA", dmem[30]);
    end
    total++;
    if (busy !== 1'b0 || halted !== 1'b0 ||
        dm_in_dbus !== 16'd0) begin
      bad++;
      $display("FAIL idle_after: got b%b h%b ac%0h want 0 0 0",
        busy, halted, dm_in_dbus);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, waits, stab;
    load_basic();
    run1(1'b1, cyc, waits, stab);
    total++;
    if (cyc !== 8 || im_abus !== 13'd4) begin
      bad++;
      $display("FAIL start_busy: got c%0d pc %0h want 8 4",
        cyc, im_abus);
    end
    total++;
    if (dmem[7] !== 16'd7) begin
      bad++;
      $display("FAIL start_busy_m7: got %0h want 7", dmem[7]);
    end
  endtask

  task automatic test_param();
    int cyc;
    rom2[0]   = i12(LDA, 511);
    rom2[1]   = i12(STA, 0);
    rom2[2]   = i12(JMP, 510);
    rom2[510] = i12(ADD, 1);
    rom2[511] = i12(HLT, 0);
    dmem2[511] = 12'hABC;
    dmem2[1]   = 12'h001;
    dmem2[0]   = 12'h000;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cyc = 0;
    while (!halted2 && cyc < 400) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc !== 10 || halted2 !== 1'b1) begin
      bad++;
      $display("FAIL p_cyc: got %0d want 10", cyc);
    end
    total++;
    if (dmem2[0] !== 12'hABC) begin
      bad++;
      $display("FAIL p_sta: got %0h want ABC", dmem2[0]);
    end
    total++;
    if (dm_in2 !== 12'hABD) begin
      bad++;
      $display("FAIL p_ac: got %0h want ABD", dm_in2);
    end
    total++;
    if (im_abus2 !== 9'd0) begin
      bad++;
      $display("FAIL p_wrap: got %0h want 0", im_abus2);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    nwait = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      rom[i] = 16'd0;
      dmem[i] = 16'd0;
    end
    for (int i = 0; i < 512; i++) begin
      rom2[i] = 12'd0;
      dmem2[i] = 12'd0;
    end
    test_reset();
    test_basic();
    test_wait_states();
    test_arith();
    test_jumps();
    test_reset_in_wait();
    test_back_to_back();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
